tb_ram_arbiter: RTL and testbench

TB_RAM_ARBITER -- requirements
Module: tb_ram_arbiter

---
 rtl/tb_ram_arbiter_pkg.sv | 28 ++
 rtl/tb_rr_pick.sv | 26 ++
 rtl/tb_ram_arbiter.sv | 130 +++++++++++++
 tb/tb_tb_ram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_ram_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// Holds the FSM state encoding, the latched request record and the requester count.
package tb_ram_arbiter_pkg;

  localparam int NUM_REQUESTERS = 2;
  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int MASK_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } req_t;

  // Index of the single set bit in a one-hot grant vector.
  function automatic logic grant_index(input logic [NUM_REQUESTERS-1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/tb_rr_pick.sv
// Two-way winner selection: round-robin against the last grant, or fixed priority to
// requester 0. Output is one-hot, or all-zero when nobody is valid.
module tb_rr_pick
  import tb_ram_arbiter_pkg::*;
(
  input  logic [NUM_REQUESTERS-1:0] valid,
  input  logic                      last_grant,
  input  logic                      fixed_priority,
  output logic [NUM_REQUESTERS-1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid[0] && valid[1]) begin
      // Contention: requester 0 wins under fixed priority or when 1 was granted last.
      if (fixed_priority || last_grant) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/tb_ram_arbiter.sv
// Arbitrates two request ports onto a single RAM port with registered read data.
// Each transaction takes ISSUE then RESPOND; a new request can be taken during RESPOND.
module tb_ram_arbiter
  import tb_ram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [MASK_W-1:0] req0_mask,
  input  logic [DATA_W-1:0] req0_write_data,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_read_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic [MASK_W-1:0] req1_mask,
  input  logic [DATA_W-1:0] req1_write_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_read_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write_enable,
  output logic [MASK_W-1:0] ram_write_mask,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_read_enable,
  output logic [MASK_W-1:0] ram_read_mask,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic              busy
);

  state_e                    state_q, state_d, state_eff;
  req_t                      req_q, req_d;
  logic                      owner_q, owner_d;
  logic                      last_q, last_d;
  logic [NUM_REQUESTERS-1:0] valid_vec;
  logic [NUM_REQUESTERS-1:0] grant;
  logic [NUM_REQUESTERS-1:0] ready_vec;
  logic [NUM_REQUESTERS-1:0] rsp_valid_vec;
  logic [DATA_W-1:0]         rsp_data;
  logic                      accept;
  req_t                      req_in [NUM_REQUESTERS];

  assign valid_vec = {req1_valid, req0_valid};
  assign req_in[0] = {req0_write, req0_address, req0_mask, req0_write_data};
  assign req_in[1] = {req1_write, req1_address, req1_mask, req1_write_data};

  tb_rr_pick u_pick (
    .valid          (valid_vec),
    .last_grant     (last_q),
    .fixed_priority (FIXED_PRIORITY != 0),
    .grant          (grant)
  );

  // While reset is high every output behaves as in IDLE, which also blocks acceptance
  // and suppresses any in-flight strobe or response in that same cycle.
  assign state_eff = reset ? ST_IDLE : state_q;
  assign accept    = !reset && (state_eff != ST_ISSUE) && (|valid_vec);

  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    owner_d          = owner_q;
    last_d           = last_q;
    ready_vec        = '0;
    rsp_valid_vec    = '0;
    rsp_data         = '0;
    ram_address      = '0;
    ram_write_enable = 1'b0;
    ram_write_mask   = '0;
    ram_write_data   = '0;
    ram_read_enable  = 1'b0;
    ram_read_mask    = '0;
    busy             = (state_eff != ST_IDLE);

    case (state_eff)
      ST_ISSUE: begin
        ram_address      = req_q.address;
        ram_write_data   = req_q.data;
        ram_write_enable = req_q.write;
        ram_write_mask   = req_q.write ? req_q.mask : '0;
        ram_read_enable  = !req_q.write;
        ram_read_mask    = req_q.write ? '0 : req_q.mask;
        state_d          = ST_RESPOND;
      end
      ST_RESPOND: begin
        rsp_valid_vec[owner_q] = 1'b1;
        rsp_data               = req_q.write ? '0 : ram_read_data;
        state_d                = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      ready_vec = grant;
      req_d     = req_in[grant_index(grant)];
      owner_d   = grant_index(grant);
      last_d    = grant_index(grant);
      state_d   = ST_ISSUE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign req0_ready     = ready_vec[0];
  assign req1_ready     = ready_vec[1];
  assign rsp0_valid     = rsp_valid_vec[0];
  assign rsp1_valid     = rsp_valid_vec[1];
  assign rsp0_read_data = rsp_valid_vec[0] ? rsp_data : '0;
  assign rsp1_read_data = rsp_valid_vec[1] ? rsp_data : '0;

endmodule

// File: tb/tb_tb_ram_arbiter.sv
// Bench for tb_ram_arbiter: a round-robin and a fixed-priority instance side by side,
// each with its own RAM, checked every cycle against a timing/transaction model.
module tb_tb_ram_arbiter;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    int          inst;
    int          req;
    int          t;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_clr = 1'b0;
  logic [1:0]  v [2], wr [2], rdy [2], rv [2];
  logic [31:0] addr [2][2], wdata [2][2], rdata [2][2];
  logic [3:0]  mask [2][2];
  logic [31:0] ram_addr [2], ram_wdata [2], ram_rdata [2];
  logic        ram_we [2], ram_re [2], busy [2];
  logic [3:0]  ram_wmask [2], ram_rmask [2];
  logic [31:0] mem [2][256];

  txn_t        rq [2][2][$];
  ev_t         exp_q[$], acc_log[$], rsp_log[$];
  txn_t        iss_txn [2];
  int          iss_req [2], last_acc [2], m_last [2];
  int          cyc;
  logic [31:0] ref_mem [2][256];
  int          n_checks = 0;
  int          n_errors = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      tb_ram_arbiter #(.FIXED_PRIORITY(gi)) u_dut (
        .clock(clk), .reset(rst),
        .req0_valid(v[gi][0]), .req0_ready(rdy[gi][0]), .req0_write(wr[gi][0]),
        .req0_address(addr[gi][0]), .req0_mask(mask[gi][0]), .req0_write_data(wdata[gi][0]),
        .rsp0_valid(rv[gi][0]), .rsp0_read_data(rdata[gi][0]),
        .req1_valid(v[gi][1]), .req1_ready(rdy[gi][1]), .req1_write(wr[gi][1]),
        .req1_address(addr[gi][1]), .req1_mask(mask[gi][1]), .req1_write_data(wdata[gi][1]),
        .rsp1_valid(rv[gi][1]), .rsp1_read_data(rdata[gi][1]),
        .ram_address(ram_addr[gi]), .ram_write_enable(ram_we[gi]), .ram_write_mask(ram_wmask[gi]),
        .ram_write_data(ram_wdata[gi]), .ram_read_enable(ram_re[gi]), .ram_read_mask(ram_rmask[gi]),
        .ram_read_data(ram_rdata[gi]), .busy(busy[gi])
      );
    end
  endgenerate

  initial forever #5 clk = ~clk;

  // Word-addressed RAM with byte-lane writes and one-cycle registered reads.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_clr) begin
        for (int k = 0; k < 256; k++) mem[i][k] <= '0;
        ram_rdata[i] <= '0;
      end else begin
        if (ram_we[i])
          for (int b = 0; b < 4; b++)
            if (ram_wmask[i][b]) mem[i][ram_addr[i][9:2]][8*b +: 8] <= ram_wdata[i][8*b +: 8];
        if (ram_re[i]) ram_rdata[i] <= mem[i][ram_addr[i][9:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_txn(input int i, input int n, input bit w, input logic [31:0] a,
                          input logic [3:0] m, input logic [31:0] d);
    txn_t t;
    t.wr = w; t.addr = a; t.mask = m; t.data = d;
    rq[i][n].push_back(t);
  endtask

  // One clock cycle: drive, predict, sample at negedge, then advance the model.
  task automatic run_cycle(input bit do_rst, input bit rnd, input bit clr);
    int          win [2];
    bit          issue [2], exp_rv [2][2];
    logic [31:0] exp_rd [2][2];
    logic [31:0] a, d;
    bit          exp_busy;
    rst = do_rst;
    mem_clr = clr;
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (rnd && $urandom_range(0, 2) == 0 && rq[i][n].size() < 3) begin
          a = $urandom;
          a[9:6] = '0;
          push_txn(i, n, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
        end
        if (rq[i][n].size() > 0) begin
          v[i][n] = 1'b1; wr[i][n] = rq[i][n][0].wr; addr[i][n] = rq[i][n][0].addr;
          mask[i][n] = rq[i][n][0].mask; wdata[i][n] = rq[i][n][0].data;
        end else begin
          v[i][n] = 1'b0; wr[i][n] = 1'b0; addr[i][n] = '0; mask[i][n] = '0; wdata[i][n] = '0;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      win[i] = -1;
      if (!do_rst && cyc != last_acc[i] + 1) begin
        if (v[i][0] && v[i][1]) win[i] = (i == 1 || m_last[i] == 1) ? 0 : 1;
        else if (v[i][0]) win[i] = 0;
        else if (v[i][1]) win[i] = 1;
      end
      issue[i] = !do_rst && (cyc == last_acc[i] + 1);
      for (int n = 0; n < 2; n++) begin
        exp_rv[i][n] = 1'b0;
        exp_rd[i][n] = '0;
      end
      foreach (exp_q[k])
        if (exp_q[k].inst == i && exp_q[k].t == cyc && !do_rst) begin
          exp_rv[i][exp_q[k].req] = 1'b1;
          exp_rd[i][exp_q[k].req] = exp_q[k].data;
        end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      exp_busy = !do_rst && (cyc == last_acc[i] + 1 || cyc == last_acc[i] + 2);
      check($sformatf("i%0d_busy", i), 32'(busy[i]), 32'(exp_busy));
      for (int n = 0; n < 2; n++) begin
        check($sformatf("i%0d_ready%0d", i, n), 32'(rdy[i][n]), 32'(win[i] == n));
        check($sformatf("i%0d_rsp_valid%0d", i, n), 32'(rv[i][n]), 32'(exp_rv[i][n]));
        if (exp_rv[i][n] || do_rst)
          check($sformatf("i%0d_rsp_data%0d", i, n), rdata[i][n], exp_rd[i][n]);
      end
      check($sformatf("i%0d_ram_we", i), 32'(ram_we[i]), 32'(issue[i] && iss_txn[i].wr));
      check($sformatf("i%0d_ram_re", i), 32'(ram_re[i]), 32'(issue[i] && !iss_txn[i].wr));
      check($sformatf("i%0d_ram_wmask", i), 32'(ram_wmask[i]),
            (issue[i] && iss_txn[i].wr) ? 32'(iss_txn[i].mask) : 32'h0);
      check($sformatf("i%0d_ram_rmask", i), 32'(ram_rmask[i]),
            (issue[i] && !iss_txn[i].wr) ? 32'(iss_txn[i].mask) : 32'h0);
      if (issue[i]) check($sformatf("i%0d_ram_addr", i), ram_addr[i], iss_txn[i].addr);
      if (issue[i] && iss_txn[i].wr) check($sformatf("i%0d_ram_wdata", i), ram_wdata[i], iss_txn[i].data);
      if (do_rst) check($sformatf("i%0d_rst_addr", i), ram_addr[i], 32'h0);
    end
    for (int i = 0; i < 2; i++) begin
      if (issue[i]) begin
        d = '0;
        if (iss_txn[i].wr) begin
          for (int b = 0; b < 4; b++)
            if (iss_txn[i].mask[b]) ref_mem[i][iss_txn[i].addr[9:2]][8*b +: 8] = iss_txn[i].data[8*b +: 8];
        end else begin
          d = ref_mem[i][iss_txn[i].addr[9:2]];
        end
        exp_q.push_back('{i, iss_req[i], cyc + 1, d});
      end
      if (win[i] >= 0) begin
        iss_txn[i] = rq[i][win[i]].pop_front();
        iss_req[i] = win[i];
        last_acc[i] = cyc;
        m_last[i] = win[i];
        acc_log.push_back('{i, win[i], cyc, 32'h0});
      end
      if (do_rst) begin
        last_acc[i] = -10;
        m_last[i] = 1;
      end
      for (int n = 0; n < 2; n++)
        if (rv[i][n]) rsp_log.push_back('{i, n, cyc, rdata[i][n]});
    end
    for (int k = exp_q.size() - 1; k >= 0; k--)
      if (exp_q[k].t <= cyc) exp_q.delete(k);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) run_cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    ev_t sel[$];
    int  start, start2;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 256; k++) ref_mem[i][k] = '0;
      last_acc[i] = -10; m_last[i] = 1; iss_req[i] = 0;
      iss_txn[i] = '{1'b0, 32'h0, 4'h0, 32'h0};
      v[i] = '0; wr[i] = '0;
      for (int n = 0; n < 2; n++) begin
        addr[i][n] = '0; mask[i][n] = '0; wdata[i][n] = '0;
      end
    end
    cyc = 0;
    @(posedge clk);
    #1;
    run_cycle(1'b1, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b0, 1'b1);
    run_n(2);

    // Single read after preloading the word through the arbiter.
    push_txn(0, 0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
    run_n(3);
    start = cyc;
    push_txn(0, 0, 1'b0, 32'h100, 4'hF, 32'h0);
    run_n(4);
    sel = acc_log.find(e) with (e.inst == 0 && e.t >= start);
    check("single_acc_count", 32'(sel.size()), 32'd1);
    if (sel.size() > 0) check("single_acc_cycle", 32'(sel[0].t - start), 32'd0);
    sel = rsp_log.find(e) with (e.inst == 0 && e.t >= start);
    check("single_rsp_count", 32'(sel.size()), 32'd1);
    if (sel.size() > 0) begin
      check("single_rsp_cycle", 32'(sel[0].t - start), 32'd2);
      check("single_rsp_data", sel[0].data, 32'hDEADBEEF);
    end

    // Round-robin contention, three reads per requester.
    run_cycle(1'b1, 1'b0, 1'b0);
    start = cyc;
    for (int k = 0; k < 3; k++) begin
      push_txn(0, 0, 1'b0, 32'h300 + 32'(4 * k), 4'hF, 32'h0);
      push_txn(0, 1, 1'b0, 32'h340 + 32'(4 * k), 4'hF, 32'h0);
    end
    run_n(13);
    sel = acc_log.find(e) with (e.inst == 0 && e.t >= start);
    check("rr_acc_count", 32'(sel.size()), 32'd6);
    for (int k = 0; k < sel.size() && k < 6; k++) begin
      check($sformatf("rr_grant%0d", k), 32'(sel[k].req), 32'(k % 2));
      check($sformatf("rr_cycle%0d", k), 32'(sel[k].t - start), 32'(2 * k));
    end

    // Fixed priority: requester 1 waits until requester 0 runs out.
    run_cycle(1'b1, 1'b0, 1'b0);
    start = cyc;
    for (int k = 0; k < 4; k++) push_txn(1, 0, 1'b0, 32'h400 + 32'(4 * k), 4'hF, 32'h0);
    for (int k = 0; k < 2; k++) push_txn(1, 1, 1'b0, 32'h440 + 32'(4 * k), 4'hF, 32'h0);
    run_n(13);
    sel = acc_log.find(e) with (e.inst == 1 && e.t >= start);
    check("fp_acc_count", 32'(sel.size()), 32'd6);
    for (int k = 0; k < sel.size() && k < 6; k++) begin
      check($sformatf("fp_grant%0d", k), 32'(sel[k].req), (k < 4) ? 32'd0 : 32'd1);
      check($sformatf("fp_cycle%0d", k), 32'(sel[k].t - start), 32'(2 * k));
    end

    // Partial-mask write followed by a full read.
    run_cycle(1'b1, 1'b0, 1'b0);
    start = cyc;
    push_txn(0, 1, 1'b1, 32'h200, 4'b0011, 32'hCAFEF00D);
    push_txn(0, 1, 1'b0, 32'h200, 4'hF, 32'h0);
    run_n(6);
    sel = rsp_log.find(e) with (e.inst == 0 && e.t >= start);
    check("wr_rd_rsp_count", 32'(sel.size()), 32'd2);
    if (sel.size() >= 2) begin
      check("wr_rsp_data", sel[0].data, 32'h0);
      check("rd_rsp_req", 32'(sel[1].req), 32'd1);
      check("rd_rsp_data", sel[1].data, 32'h0000F00D);
    end

    // Reset in the ISSUE cycle drops the read; next contention goes to requester 0.
    run_cycle(1'b1, 1'b0, 1'b0);
    start = cyc;
    push_txn(0, 0, 1'b0, 32'h100, 4'hF, 32'h0);
    run_cycle(1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0);
    run_n(3);
    sel = rsp_log.find(e) with (e.inst == 0 && e.t >= start);
    check("rst_drop_rsp_count", 32'(sel.size()), 32'd0);
    start2 = cyc;
    push_txn(0, 0, 1'b0, 32'h104, 4'hF, 32'h0);
    push_txn(0, 1, 1'b0, 32'h108, 4'hF, 32'h0);
    run_n(5);
    sel = acc_log.find(e) with (e.inst == 0 && e.t >= start2);
    check("rst_next_acc_count", 32'(sel.size()), 32'd2);
    if (sel.size() > 0) check("rst_next_grant", 32'(sel[0].req), 32'd0);

    // Randomized traffic with occasional resets, then drain.
    for (int k = 0; k < 600; k++)
      run_cycle(1'($urandom_range(0, 99) == 0), 1'b1, 1'b0);
    run_n(16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
